// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core constants: ROB geometry, CDB requester indices and default widths.
package tomasulo_pkg;

  localparam int ROB_DEPTH  = 8;
  localparam int ROB_TAG_W  = 3;
  localparam int CDB_DATA_W = 16;

  localparam int SRC_ADD = 0;
  localparam int SRC_MUL = 1;
  localparam int SRC_BCH = 2;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotating priority encoder: the first set request at or after ptr (mod N) wins.
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  always_comb begin
    logic found;
    int   idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one grant per cycle, winner registered onto the CDB for one cycle.
// Build option CDB_AGE_PRIORITY_EN selects oldest-ROB-tag priority instead of round-robin.
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int DATA_W = CDB_DATA_W,
  parameter int N_REQ  = 3,
  parameter int TAG_W  = ROB_TAG_W
) (
  input  logic                    clk1,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [TAG_W-1:0]        rob_head,
  input  logic                    flush,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [1:0]              cdb_src,
  output logic [15:0]             conflict_cnt
);

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [1:0]        cdb_src_q, cdb_src_d;
  logic [15:0]       conflict_cnt_q, conflict_cnt_d;

  logic [N_REQ-1:0]  rr_gnt, pick_gnt;
  logic [1:0]        win_idx;
  int                n_valid;

  rr_pick #(.N(N_REQ), .PTR_W(2)) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (rr_gnt)
  );

`ifdef CDB_AGE_PRIORITY_EN
  // Age is distance from the ROB head; strict '<' keeps ties on the lowest index.
  always_comb begin
    logic             found;
    logic [TAG_W-1:0] age, best_age;
    pick_gnt = '0;
    found    = 1'b0;
    age      = '0;
    best_age = '0;
    for (int i = 0; i < N_REQ; i++) begin
      age = req_tag[i*TAG_W +: TAG_W] - rob_head;
      if (req_valid[i] && (!found || age < best_age)) begin
        pick_gnt    = '0;
        pick_gnt[i] = 1'b1;
        best_age    = age;
        found       = 1'b1;
      end
    end
  end
  logic unused_rr_gnt;
  assign unused_rr_gnt = &{1'b0, rr_gnt};
`else
  assign pick_gnt = rr_gnt;
  logic unused_rob_head;
  assign unused_rob_head = &{1'b0, rob_head};
`endif

  assign req_ready = (rst_n && !flush) ? pick_gnt : '0;

  always_comb begin
    win_idx = 2'd0;
    n_valid = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) win_idx = 2'(i);
      if (req_valid[i]) n_valid++;
    end
  end

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    cdb_valid_d    = 1'b0;
    cdb_tag_d      = cdb_tag_q;
    cdb_data_d     = cdb_data_q;
    cdb_src_d      = cdb_src_q;
    conflict_cnt_d = conflict_cnt_q;
    if (|req_ready) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = req_tag[win_idx*TAG_W +: TAG_W];
      cdb_data_d  = req_data[win_idx*DATA_W +: DATA_W];
      cdb_src_d   = win_idx;
      rr_ptr_d    = (win_idx == 2'(N_REQ-1)) ? 2'd0 : win_idx + 2'd1;
    end
    if (n_valid >= 2 && !flush && conflict_cnt_q != 16'hFFFF)
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      rr_ptr_q       <= '0;
      cdb_valid_q    <= 1'b0;
      cdb_tag_q      <= '0;
      cdb_data_q     <= '0;
      cdb_src_q      <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      cdb_valid_q    <= cdb_valid_d;
      cdb_tag_q      <= cdb_tag_d;
      cdb_data_q     <= cdb_data_d;
      cdb_src_q      <= cdb_src_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_data     = cdb_data_q;
  assign cdb_src      = cdb_src_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single grant, round-robin rotation, flush, age mode, saturation.
module tb_cdb_arbiter;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [8:0]  req_tag;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic [2:0]  rob_head;
  logic        flush;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic [1:0]  cdb_src;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk1 = ~clk1;

  cdb_arbiter dut (
    .clk1         (clk1),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_tag      (req_tag),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rob_head     (rob_head),
    .flush        (flush),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_src      (cdb_src),
    .conflict_cnt (conflict_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 3'b111;
    req_tag   = '0;
    req_data  = '0;
    rob_head  = 3'd0;
    flush     = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    step();
    check("rst_valid", 32'(cdb_valid), 32'h0);
    check("rst_cnt", 32'(conflict_cnt), 32'h0);
    check("rst_tag", 32'(cdb_tag), 32'h0);
    check("rst_src", 32'(cdb_src), 32'h0);

    // single mul requester
    rst_n     = 1'b1;
    req_valid = 3'b010;
    req_tag   = {3'd0, 3'd5, 3'd0};
    req_data  = {16'h0, 16'h00AB, 16'h0};
    #1;
    check("single_ready", 32'(req_ready), 32'h2);
    step();
    check("single_valid", 32'(cdb_valid), 32'h1);
    check("single_tag", 32'(cdb_tag), 32'h5);
    check("single_data", 32'(cdb_data), 32'h00AB);
    check("single_src", 32'(cdb_src), 32'h1);
    req_valid = 3'b000;
    #1;
    check("idle_ready", 32'(req_ready), 32'h0);
    step();
    check("idle_valid", 32'(cdb_valid), 32'h0);
    check("idle_tag_hold", 32'(cdb_tag), 32'h5);
    check("idle_cnt", 32'(conflict_cnt), 32'h0);

    // all three continuously valid from reset
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    req_valid = 3'b111;
    req_tag   = {3'd3, 3'd2, 3'd1};
    req_data  = {16'h3333, 16'h2222, 16'h1111};
    #1;
    check("rr0_ready", 32'(req_ready), 32'h1);
    step();
    check("rr0_src", 32'(cdb_src), 32'h0);
    check("rr0_data", 32'(cdb_data), 32'h1111);
    check("rr0_cnt", 32'(conflict_cnt), 32'h1);
    check("rr1_ready", 32'(req_ready), 32'h2);
    step();
    check("rr1_src", 32'(cdb_src), 32'h1);
    check("rr1_tag", 32'(cdb_tag), 32'h2);
    check("rr1_cnt", 32'(conflict_cnt), 32'h2);
    check("rr2_ready", 32'(req_ready), 32'h4);
    step();
    check("rr2_src", 32'(cdb_src), 32'h2);
    check("rr2_data", 32'(cdb_data), 32'h3333);
    check("rr2_valid", 32'(cdb_valid), 32'h1);
    check("rr3_ready", 32'(req_ready), 32'h1);
    step();
    check("rr3_src", 32'(cdb_src), 32'h0);
    check("rr3_cnt", 32'(conflict_cnt), 32'h4);

    // bring rr_ptr back to add with a lone branch grant
    req_valid = 3'b100;
    #1;
    check("bch_ready", 32'(req_ready), 32'h4);
    step();
    check("bch_cnt", 32'(conflict_cnt), 32'h4);

    // flush with add and mul valid
    req_valid = 3'b011;
    flush     = 1'b1;
    #1;
    check("flush_ready", 32'(req_ready), 32'h0);
    step();
    check("flush_valid", 32'(cdb_valid), 32'h0);
    check("flush_cnt", 32'(conflict_cnt), 32'h4);
    flush = 1'b0;
    #1;
    check("post_flush_ready", 32'(req_ready), 32'h1);
    step();
    check("post_flush_src", 32'(cdb_src), 32'h0);
    check("post_flush_cnt", 32'(conflict_cnt), 32'h5);

`ifdef CDB_AGE_PRIORITY_EN
    // rr_ptr now points at mul; use add first to show age overrides it
    rob_head  = 3'd6;
    req_valid = 3'b011;
    req_tag   = {3'd0, 3'd7, 3'd1};
    #1;
    check("age_ready", 32'(req_ready), 32'h2);
    rob_head = 3'd0;
    #1;
    check("age_ready_head0", 32'(req_ready), 32'h1);
    req_tag = {3'd0, 3'd4, 3'd4};
    #1;
    check("age_tie_ready", 32'(req_ready), 32'h1);
`endif

    // saturation: reach 16'hFFFE by real conflict cycles, then hold past the top
    rst_n = 1'b0;
    req_valid = 3'b000;
    step();
    rst_n     = 1'b1;
    req_valid = 3'b011;
    for (int i = 0; i < 65534; i++) step();
    check("sat_pre", 32'(conflict_cnt), 32'hFFFE);
    step();
    check("sat_top", 32'(conflict_cnt), 32'hFFFF);
    step();
    step();
    check("sat_hold", 32'(conflict_cnt), 32'hFFFF);
    check("sat_bus_valid", 32'(cdb_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
